// File: rtl/batcharger_ctrl_gen2_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | batcharger_ctrl_gen2_if : ADC/OTP inputs and analog-core controls bundle |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface batcharger_ctrl_gen2_if #(
  parameter int DW = 8
);
  logic          en;
  logic          vtok;
  logic [DW-1:0] vbat;
  logic [DW-1:0] ibat;
  logic [DW-1:0] tbat;
  logic [DW-1:0] vcutoff;
  logic [DW-1:0] vpreset;
  logic [DW-1:0] tempmin;
  logic [DW-1:0] tempmax;
  logic [DW-1:0] tmax;
  logic [DW-1:0] iend;
  logic          tc;
  logic          cc;
  logic          cv;
  logic          imonen;
  logic          vmonen;
  logic          tmonen;
  logic [2:0]    state;
  logic          done;
  logic          fault;

  modport master (
    output en, vtok, vbat, ibat, tbat, vcutoff, vpreset, tempmin, tempmax, tmax, iend,
    input  tc, cc, cv, imonen, vmonen, tmonen, state, done, fault
  );

  modport slave (
    input  en, vtok, vbat, ibat, tbat, vcutoff, vpreset, tempmin, tempmax, tmax, iend,
    output tc, cc, cv, imonen, vmonen, tmonen, state, done, fault
  );
endinterface
`default_nettype wire

// File: rtl/batcharger_ctrl_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | batcharger_ctrl_gen2 : Li-ion charge FSM (trickle/CC/CV) with temp pause, |
// | timeout fault and hysteretic recharge.                Rev 1.0             |
// +--------------------------------------------------------------------------+
module batcharger_ctrl_gen2 #(
  parameter int            DW         = 8,
  parameter int            TDIV       = 8,
  parameter logic [DW-1:0] VMAX       = 8'hD6,
  parameter int            RECHG_HYST = 8
) (
  input  logic                  clk,
  input  logic                  rstz,
  batcharger_ctrl_gen2_if.slave bus,
  inout  wire                   dvdd,
  inout  wire                   dgnd
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_TC     = 3'd2;
  localparam logic [2:0] S_CC     = 3'd3;
  localparam logic [2:0] S_CV     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_TFAULT = 3'd6;
  localparam logic [2:0] S_TOUT   = 3'd7;

  localparam logic [DW:0] C_HYST = (DW+1)'(RECHG_HYST);

  logic [2:0]      r_state;
  logic [2:0]      r_resume;
  logic [TDIV-1:0] r_presc;
  logic [DW-1:0]   r_tcnt;
  logic            r_tc;
  logic            r_cc;
  logic            r_cv;
  logic            r_mon;
  logic            r_done;
  logic            r_fault;

  logic [2:0]      w_nxt;
  logic [2:0]      w_resume_nxt;
  logic            w_go;
  logic            w_tok;
  logic            w_timeout;
  logic            w_run;
  logic [DW:0]     w_vrech_ext;
  logic [DW-1:0]   w_vrech;
  logic            w_unused_supply;

  // Supplies pass straight through to the analog core; nothing here uses them.
  assign w_unused_supply = dvdd ^ dgnd;

  assign w_go      = bus.en && bus.vtok;
  assign w_tok     = (bus.tempmin < bus.tbat) && (bus.tbat < bus.tempmax);
  assign w_timeout = (bus.tmax != '0) && (r_tcnt >= bus.tmax);
  assign w_run     = (r_state == S_TC) || (r_state == S_CC) || (r_state == S_CV);

  // A negative recharge level clamps to zero so the unsigned compare never fires.
  assign w_vrech_ext = {1'b0, bus.vpreset} - C_HYST;
  assign w_vrech     = w_vrech_ext[DW] ? '0 : w_vrech_ext[DW-1:0];

  always_comb begin
    w_nxt        = r_state;
    w_resume_nxt = r_resume;
    if (!w_go) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_nxt = S_WAIT;
        S_WAIT: begin
          if (bus.vbat > VMAX)  w_nxt = S_DONE;
          else if (w_tok)       w_nxt = S_TC;
        end
        S_TC: begin
          if (!w_tok) begin
            w_nxt        = S_TFAULT;
            w_resume_nxt = S_TC;
          end else if (w_timeout)            w_nxt = S_TOUT;
          else if (bus.vbat > bus.vcutoff)   w_nxt = S_CC;
        end
        S_CC: begin
          if (!w_tok) begin
            w_nxt        = S_TFAULT;
            w_resume_nxt = S_CC;
          end else if (w_timeout)            w_nxt = S_TOUT;
          else if (bus.vbat >= bus.vpreset)  w_nxt = S_CV;
        end
        S_CV: begin
          if (!w_tok) begin
            w_nxt        = S_TFAULT;
            w_resume_nxt = S_CV;
          end else if (w_timeout || (bus.ibat < bus.iend)) w_nxt = S_DONE;
        end
        S_TFAULT: begin
          if (w_tok) w_nxt = r_resume;
        end
        S_TOUT: w_nxt = S_TOUT;
        S_DONE: begin
          if (bus.vbat < bus.vcutoff)  w_nxt = S_TC;
          else if (bus.vbat < w_vrech) w_nxt = S_CC;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // Timer runs only while charging, freezes across a temperature pause.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_presc <= '0;
      r_tcnt  <= '0;
    end else if (!w_go) begin
      r_presc <= '0;
      r_tcnt  <= '0;
    end else if (w_run) begin
      r_presc <= r_presc + 1'b1;
      if ((&r_presc) && !(&r_tcnt)) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end else if (r_state != S_TFAULT) begin
      r_presc <= '0;
      r_tcnt  <= '0;
    end
  end

  // Outputs decode the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state  <= S_IDLE;
      r_resume <= S_TC;
      r_tc     <= 1'b0;
      r_cc     <= 1'b0;
      r_cv     <= 1'b0;
      r_mon    <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_resume <= w_resume_nxt;
      r_tc     <= (w_nxt == S_TC);
      r_cc     <= (w_nxt == S_CC);
      r_cv     <= (w_nxt == S_CV);
      r_mon    <= (w_nxt != S_IDLE);
      r_done   <= (w_nxt == S_DONE);
      r_fault  <= (w_nxt == S_TFAULT) || (w_nxt == S_TOUT);
    end
  end

  assign bus.state  = r_state;
  assign bus.tc     = r_tc;
  assign bus.cc     = r_cc;
  assign bus.cv     = r_cv;
  assign bus.imonen = r_mon;
  assign bus.vmonen = r_mon;
  assign bus.tmonen = r_mon;
  assign bus.done   = r_done;
  assign bus.fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_batcharger_ctrl_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_batcharger_ctrl_gen2 : directed bench with a cycle-level charger model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_batcharger_ctrl_gen2;
  localparam int DW   = 8;
  localparam int TDIV = 4;
  localparam int HYST = 8;

  logic clk  = 1'b0;
  logic rstz = 1'b1;
  always #5 clk = ~clk;

  wire dvdd;
  wire dgnd;
  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  batcharger_ctrl_gen2_if #(.DW(DW)) bus ();

  batcharger_ctrl_gen2 #(
    .DW(DW), .TDIV(TDIV), .VMAX(8'hD6), .RECHG_HYST(HYST)
  ) dut (
    .clk(clk), .rstz(rstz), .bus(bus), .dvdd(dvdd), .dgnd(dgnd)
  );

  int checks = 0;
  int errors = 0;

  // Model: state as the spec's numeric code, timer as total clocks spent charging.
  int m_state  = 0;
  int m_resume = 2;
  int m_cnt    = 0;
  int ns, nr, nc;

  function automatic void model_next(input int st, input int res, input int cnt,
                                     output int nst, output int nres, output int ncnt);
    bit go, tok, tmo;
    int tcnt, vrech, vb;
    go    = bus.en && bus.vtok;
    tok   = (int'(bus.tempmin) < int'(bus.tbat)) && (int'(bus.tbat) < int'(bus.tempmax));
    tcnt  = cnt / (1 << TDIV);
    if (tcnt > 255) tcnt = 255;
    tmo   = (bus.tmax != 0) && (tcnt >= int'(bus.tmax));
    vrech = int'(bus.vpreset) - HYST;
    if (vrech < 0) vrech = 0;
    vb    = int'(bus.vbat);
    nst   = st;
    nres  = res;
    if (!go) nst = 0;
    else if (st == 0) nst = 1;
    else if (st == 1) begin
      if (vb > 214) nst = 5; else if (tok) nst = 2;
    end else if (st >= 2 && st <= 4 && !tok) begin
      nst = 6; nres = st;
    end else if (st == 2) begin
      if (tmo) nst = 7; else if (vb > int'(bus.vcutoff)) nst = 3;
    end else if (st == 3) begin
      if (tmo) nst = 7; else if (vb >= int'(bus.vpreset)) nst = 4;
    end else if (st == 4) begin
      if (tmo || int'(bus.ibat) < int'(bus.iend)) nst = 5;
    end else if (st == 6) begin
      if (tok) nst = res;
    end else if (st == 5) begin
      if (vb < int'(bus.vcutoff)) nst = 2; else if (vb < vrech) nst = 3;
    end
    if (!go) ncnt = 0;
    else if (st >= 2 && st <= 4) ncnt = (cnt < (1 << 20)) ? cnt + 1 : cnt;
    else if (st == 6) ncnt = cnt;
    else ncnt = 0;
  endfunction

  always @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      m_state  <= 0;
      m_resume <= 2;
      m_cnt    <= 0;
    end else begin
      model_next(m_state, m_resume, m_cnt, ns, nr, nc);
      m_state  <= ns;
      m_resume <= nr;
      m_cnt    <= nc;
    end
  end

  task automatic compare_cycle();
    logic [10:0] exp_v, act_v;
    exp_v = {3'(m_state), m_state == 2, m_state == 3, m_state == 4, {3{m_state != 0}},
             m_state == 5, (m_state == 6) || (m_state == 7)};
    act_v = {bus.state, bus.tc, bus.cc, bus.cv, bus.imonen, bus.vmonen, bus.tmonen,
             bus.done, bus.fault};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_compare t=%0t dut=%b model=%b", $time, act_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_cycle();
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int code, input int bound, output int n);
    n = 0;
    while (int'(bus.state) != code && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  int n;
  int seen;

  initial begin
    bus.en = 1'b0;      bus.vtok = 1'b0;
    bus.vbat = 8'd100;  bus.ibat = 8'd10;   bus.tbat = 8'd100;
    bus.vcutoff = 8'd147; bus.vpreset = 8'd188;
    bus.tempmin = 8'd50;  bus.tempmax = 8'd200;
    bus.tmax = 8'd0;    bus.iend = 8'd2;
    #1 rstz = 1'b0;
    tick(2);
    check("reset_state", int'(bus.state), 0);
    check("reset_mon", int'(bus.imonen), 0);
    check("reset_fault", int'(bus.fault), 0);
    rstz = 1'b1;
    tick(1);

    // Normal flow
    bus.en = 1'b1; bus.vtok = 1'b1;
    wait_state(2, 10, n);
    check("flow_tc_latency", n, 2);
    check("flow_tc", int'(bus.tc), 1);
    bus.vbat = 8'd150; tick(1);
    check("flow_cc", int'(bus.state), 3);
    bus.vbat = 8'd188; tick(1);
    check("flow_cv", int'(bus.cv), 1);
    bus.ibat = 8'd1; tick(1);
    check("flow_done", int'(bus.done), 1);
    check("flow_done_state", int'(bus.state), 5);

    // Temperature pause with held timer
    bus.en = 1'b0; bus.ibat = 8'd10; bus.vbat = 8'd150; tick(1);
    check("tf_idle", int'(bus.state), 0);
    bus.en = 1'b1;
    wait_state(3, 10, n);
    check("tf_cc_latency", n, 3);
    tick(40);
    bus.tbat = 8'd210; tick(1);
    check("tf_state", int'(bus.state), 6);
    check("tf_cc_off", int'(bus.cc), 0);
    check("tf_fault", int'(bus.fault), 1);
    tick(20);
    check("tf_hold", int'(bus.state), 6);
    bus.tmax = 8'd3; bus.tbat = 8'd100;
    wait_state(7, 100, n);
    check("tf_resume_timer", n, 8);

    // Timeout from TC entry
    bus.en = 1'b0; tick(1);
    bus.vbat = 8'd100; bus.en = 1'b1;
    wait_state(2, 10, n);
    wait_state(7, 200, n);
    check("tout_latency", n, 49);
    check("tout_fault", int'(bus.fault), 1);
    tick(10);
    check("tout_sticky", int'(bus.state), 7);
    bus.en = 1'b0; tick(1);
    check("tout_exit", int'(bus.state), 0);

    // WAIT bypass straight to DONE
    bus.tmax = 8'd0; bus.vbat = 8'd215; bus.en = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (bus.tc || bus.cc || bus.cv) seen++;
    end
    check("bypass_no_mode", seen, 0);
    check("bypass_done", int'(bus.state), 5);

    // Recharge hysteresis
    bus.vbat = 8'd180; tick(3);
    check("rech_hold", int'(bus.state), 5);
    bus.vbat = 8'd179; tick(1);
    check("rech_cc", int'(bus.state), 3);
    bus.vbat = 8'd188; tick(1);
    bus.ibat = 8'd1; tick(1);
    check("rech_done2", int'(bus.state), 5);
    bus.vbat = 8'd140; tick(1);
    check("rech_tc", int'(bus.tc), 1);
    bus.ibat = 8'd10;

    // Temperature window boundary in WAIT
    bus.en = 1'b0; tick(1);
    bus.tbat = 8'd50; bus.vbat = 8'd100; bus.en = 1'b1;
    tick(5);
    check("tmin_boundary", int'(bus.state), 1);
    bus.tbat = 8'd51; tick(1);
    check("tmin_plus1", int'(bus.state), 2);

    // Async reset mid-CV, then vtok drop in CC
    bus.vbat = 8'd150; tick(1);
    bus.vbat = 8'd188; tick(1);
    check("ar_cv", int'(bus.cv), 1);
    #2 rstz = 1'b0;
    #1;
    check("ar_state", int'(bus.state), 0);
    check("ar_cv_off", int'(bus.cv), 0);
    tick(2);
    rstz = 1'b1;
    wait_state(3, 10, n);
    check("vtok_cc", int'(bus.state), 3);
    bus.vtok = 1'b0; tick(1);
    check("vtok_idle", int'(bus.state), 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
